rule_dispatch_1t2: RTL

RULE_DISPATCH_1T2 -- requirements
Module: rule_dispatch_1t2

---
 rtl/rule_dispatch_1t2_pkg.sv | 22 ++
 rtl/rule_dispatch_1t2_fifo.sv | 68 ++++++
 rtl/rule_dispatch_1t2.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rule_dispatch_1t2_pkg.sv
// Shared rule type for the rule dispatcher (package struct_s).
// Provides rule_s_t, its width and a zero constant used for resets.
package struct_s;

    localparam int RULE_S_WIDTH = 32;

    typedef struct packed {
        logic        last;
        logic [7:0]  action;
        logic [22:0] key;
    } rule_s_t;

    localparam rule_s_t RULE_S_ZERO = rule_s_t'(32'h0000_0000);

    // Routing choice for a non-last rule: stay on ptr unless that FIFO is full.
    function automatic logic pick_target(input logic ptr, input logic full0, input logic full1);
        logic ptr_full;
        ptr_full = ptr ? full1 : full0;
        return ptr_full ? ~ptr : ptr;
    endfunction

endpackage

// File: rtl/rule_dispatch_1t2_fifo.sv
// dispatch_fifo: single-clock show-ahead FIFO with synchronous active-low reset.
// A write while full is refused even if the head is popped in the same cycle.
// The head reads as zero while the FIFO is empty.
module dispatch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == CW'(1'b0));
    assign count   = count_q;
    assign push_s  = wr_en & ~full;
    assign pop_s   = rd_en & ~empty;
    assign rd_data = empty ? WIDTH'(1'b0) : mem_q[rd_ptr_q];

    // Occupancy update: push+pop together keeps the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset clears everything so nothing stale is emitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(1'b0);
            end
            wr_ptr_q <= AW'(1'b0);
            rd_ptr_q <= AW'(1'b0);
            count_q  <= CW'(1'b0);
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rule_dispatch_1t2.sv
// rule_dispatch_1t2: splits a rule stream across two output FIFOs, alternating
// non-last rules and broadcasting the packet-end marker to both outputs.
// Optional feature macro RULE_DISPATCH_DEDUP_EN drops a non-last rule that
// repeats the previous written rule of the same packet and counts it on drop_cnt.
module rule_dispatch_1t2
    import struct_s::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  rule_s_t     in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output rule_s_t     out_data_0,
    output rule_s_t     out_data_1,
    output logic        out_valid_0,
    output logic        out_valid_1,
    input  logic        out_ready_0,
    input  logic        out_ready_1,
    output logic [31:0] rule_cnt,
`ifdef RULE_DISPATCH_DEDUP_EN
    output logic [31:0] drop_cnt,
`endif
    output logic [31:0] last_cnt
);

    typedef enum logic {RUN = 1'b0, BCAST = 1'b1} state_e;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [1:0]              sent_mask_q, sent_mask_d;
    rule_s_t                 pending_q, pending_d;
    logic [31:0]             rule_cnt_q, rule_cnt_d;
    logic [31:0]             last_cnt_q, last_cnt_d;

    logic                    ready_s;
    logic                    wr0_s, wr1_s;
    rule_s_t                 wr_data_s;
    logic [RULE_S_WIDTH-1:0] wr_vec_s;
    logic                    target_s;
    logic                    full0_s, full1_s;
    logic                    empty0_s, empty1_s;
    logic [CW-1:0]           cnt0_s, cnt1_s;
    logic [RULE_S_WIDTH-1:0] rd0_s, rd1_s;
    logic                    unused_cnt_s;

`ifdef RULE_DISPATCH_DEDUP_EN
    rule_s_t                 cache_q, cache_d;
    logic                    cache_vld_q, cache_vld_d;
    logic [31:0]             drop_cnt_q, drop_cnt_d;
    logic                    dup_hit_s;

    assign dup_hit_s = in_valid & ~in_data.last & cache_vld_q & (in_data == cache_q);
    assign drop_cnt  = drop_cnt_q;
`endif

    assign target_s     = pick_target(ptr_q, full0_s, full1_s);
    assign wr_vec_s     = wr_data_s;
    assign in_ready     = rst_n & ready_s;
    assign out_data_0   = rule_s_t'(rd0_s);
    assign out_data_1   = rule_s_t'(rd1_s);
    assign out_valid_0  = ~empty0_s;
    assign out_valid_1  = ~empty1_s;
    assign rule_cnt     = rule_cnt_q;
    assign last_cnt     = last_cnt_q;
    assign unused_cnt_s = ^{cnt0_s, cnt1_s};

    dispatch_fifo #(.WIDTH(RULE_S_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr0_s),
        .wr_data (wr_vec_s),
        .rd_en   (out_ready_0),
        .rd_data (rd0_s),
        .full    (full0_s),
        .empty   (empty0_s),
        .count   (cnt0_s)
    );

    dispatch_fifo #(.WIDTH(RULE_S_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr1_s),
        .wr_data (wr_vec_s),
        .rd_en   (out_ready_1),
        .rd_data (rd1_s),
        .full    (full1_s),
        .empty   (empty1_s),
        .count   (cnt1_s)
    );

    // Dispatch decisions: routing, marker broadcast, BCAST completion and counters.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sent_mask_d = sent_mask_q;
        pending_d   = pending_q;
        rule_cnt_d  = rule_cnt_q;
        last_cnt_d  = last_cnt_q;
        ready_s     = 1'b0;
        wr0_s       = 1'b0;
        wr1_s       = 1'b0;
        wr_data_s   = in_data;
`ifdef RULE_DISPATCH_DEDUP_EN
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        drop_cnt_d  = drop_cnt_q;
`endif
        case (state_q)
            RUN: begin
`ifdef RULE_DISPATCH_DEDUP_EN
                if (dup_hit_s) begin
                    // Repeat of the last written rule: swallow it, nothing else moves.
                    ready_s    = 1'b1;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end else
`endif
                begin
                    ready_s = ~full0_s | ~full1_s;
                    if (in_valid && ready_s) begin
                        if (in_data.last) begin
                            wr0_s = ~full0_s;
                            wr1_s = ~full1_s;
`ifdef RULE_DISPATCH_DEDUP_EN
                            cache_vld_d = 1'b0;
`endif
                            if (!full0_s && !full1_s) begin
                                last_cnt_d = last_cnt_q + 32'd1;
                                ptr_d      = 1'b0;
                            end else begin
                                // One side is full: finish the broadcast later.
                                pending_d   = in_data;
                                sent_mask_d = {~full1_s, ~full0_s};
                                state_d     = BCAST;
                            end
                        end else begin
                            wr0_s      = ~target_s;
                            wr1_s      = target_s;
                            ptr_d      = ~target_s;
                            rule_cnt_d = rule_cnt_q + 32'd1;
`ifdef RULE_DISPATCH_DEDUP_EN
                            cache_d     = in_data;
                            cache_vld_d = 1'b1;
`endif
                        end
                    end else begin
                        ptr_d = ptr_q;
                    end
                end
            end
            BCAST: begin
                ready_s   = 1'b0;
                wr_data_s = pending_q;
                if ((sent_mask_q[0] && !full1_s) || (sent_mask_q[1] && !full0_s)) begin
                    wr0_s       = sent_mask_q[1];
                    wr1_s       = sent_mask_q[0];
                    state_d     = RUN;
                    last_cnt_d  = last_cnt_q + 32'd1;
                    ptr_d       = 1'b0;
                    sent_mask_d = 2'b00;
                    pending_d   = RULE_S_ZERO;
                end else begin
                    state_d = BCAST;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control and counter registers; reset abandons any pending broadcast.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ptr_q       <= 1'b0;
            sent_mask_q <= 2'b00;
            pending_q   <= RULE_S_ZERO;
            rule_cnt_q  <= 32'd0;
            last_cnt_q  <= 32'd0;
`ifdef RULE_DISPATCH_DEDUP_EN
            cache_q     <= RULE_S_ZERO;
            cache_vld_q <= 1'b0;
            drop_cnt_q  <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sent_mask_q <= sent_mask_d;
            pending_q   <= pending_d;
            rule_cnt_q  <= rule_cnt_d;
            last_cnt_q  <= last_cnt_d;
`ifdef RULE_DISPATCH_DEDUP_EN
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

endmodule
